min_detect_stream: RTL and testbench

MIN_DETECT_STREAM -- requirements
Module: min_detect_stream

---
 rtl/fft_bfp_pkg.sv | 17 +
 rtl/min_detect_stream_if.sv | 31 +++
 rtl/min_idx_2in.sv | 28 ++
 rtl/min_detect_stream.sv | 190 +++++++++++++++++++
 tb/tb_min_detect_stream.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_bfp_pkg.sv
// Shared definitions for the min-detect stream block: lane-width default,
// FSM state encoding and the lane-index width helper.
package fft_bfp_pkg;

   localparam int LZC_WIDTH_DEF = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } fsm_state_e;

   // Width of a lane index; a single lane still needs one bit to carry it.
   function automatic int lane_idx_w(input int num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

endpackage

// File: rtl/min_detect_stream_if.sv
// Beat stream in, frame result out. The master drives beats; the slave is the
// detector that returns one result per frame.
interface min_detect_stream_if
   import fft_bfp_pkg::*;
#(
   parameter int LZC_WIDTH = LZC_WIDTH_DEF,
   parameter int NUM_IN    = 16,
   parameter int BEAT_W    = 8
);
   localparam int IDX_W = lane_idx_w(NUM_IN);

   logic                 in_valid;
   logic                 in_last;
   logic [LZC_WIDTH-1:0] min_in [0:NUM_IN-1];
   logic                 frame_valid;
   logic [LZC_WIDTH-1:0] frame_min;
   logic [IDX_W-1:0]     frame_lane;
   logic [BEAT_W-1:0]    frame_beat;
   logic                 frame_sat;

   modport master (
      output in_valid, in_last, min_in,
      input  frame_valid, frame_min, frame_lane, frame_beat, frame_sat
   );

   modport slave (
      input  in_valid, in_last, min_in,
      output frame_valid, frame_min, frame_lane, frame_beat, frame_sat
   );

endinterface

// File: rtl/min_idx_2in.sv
// One compare-tree node: passes on the smaller value with its lane index;
// on equal values the lower lane index wins.
module min_idx_2in
   import fft_bfp_pkg::*;
#(
   parameter int VAL_W = LZC_WIDTH_DEF,
   parameter int IDX_W = 4
) (
   input  logic [VAL_W-1:0] i_a_val,
   input  logic [IDX_W-1:0] i_a_idx,
   input  logic [VAL_W-1:0] i_b_val,
   input  logic [IDX_W-1:0] i_b_idx,
   output logic [VAL_W-1:0] o_val,
   output logic [IDX_W-1:0] o_idx
);

   // Select operand b only when it is strictly better.
   always_comb begin
      if ((i_b_val < i_a_val) || ((i_b_val == i_a_val) && (i_b_idx < i_a_idx))) begin
         o_val = i_b_val;
         o_idx = i_b_idx;
      end else begin
         o_val = i_a_val;
         o_idx = i_a_idx;
      end
   end

endmodule

// File: rtl/min_detect_stream.sv
// Per-frame minimum finder: input register, heap-ordered compare tree split by
// Stage A after level PIPE_LVL, then an IDLE/ACCUM frame accumulator.
module min_detect_stream
   import fft_bfp_pkg::*;
#(
   parameter int LZC_WIDTH = LZC_WIDTH_DEF,
   parameter int NUM_IN    = 16,
   parameter int PIPE_LVL  = 2,
   parameter int BEAT_W    = 8
) (
   input logic               clk,
   input logic               rstn,
   input logic               en,
   min_detect_stream_if.slave stream
);

   localparam int IDX_W = lane_idx_w(NUM_IN);
   localparam int NUM_A = NUM_IN >> PIPE_LVL;
   localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};

   logic                 r_in_vld;
   logic                 r_in_last;
   logic [LZC_WIDTH-1:0] r_in_val [0:NUM_IN-1];

   // Heap numbering: node n has children 2n and 2n+1, leaves sit at NUM_IN + lane.
   logic [LZC_WIDTH-1:0] w_fv [NUM_A:2*NUM_IN-1];
   logic [IDX_W-1:0]     w_fi [NUM_A:2*NUM_IN-1];

   logic                 r_a_vld;
   logic                 r_a_last;
   logic [LZC_WIDTH-1:0] r_av [NUM_A:2*NUM_A-1];
   logic [IDX_W-1:0]     r_ai [NUM_A:2*NUM_A-1];

   logic [LZC_WIDTH-1:0] w_bv [1:2*NUM_A-1];
   logic [IDX_W-1:0]     w_bi [1:2*NUM_A-1];

   fsm_state_e           r_state;
   logic [LZC_WIDTH-1:0] r_acc_val;
   logic [IDX_W-1:0]     r_acc_lane;
   logic [BEAT_W-1:0]    r_acc_beat;
   logic [BEAT_W-1:0]    r_cnt;
   logic                 r_full;

   logic                 w_take;
   logic [LZC_WIDTH-1:0] w_new_val;
   logic [IDX_W-1:0]     w_new_lane;
   logic [BEAT_W-1:0]    w_new_beat;

   logic                 r_frame_valid;
   logic [LZC_WIDTH-1:0] r_frame_min;
   logic [IDX_W-1:0]     r_frame_lane;
   logic [BEAT_W-1:0]    r_frame_beat;
   logic                 r_frame_sat;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_leaf
         assign w_fv[NUM_IN+gi] = r_in_val[gi];
         assign w_fi[NUM_IN+gi] = IDX_W'(gi);
      end
      for (gi = NUM_A; gi < NUM_IN; gi++) begin : g_front_node
         min_idx_2in #(.VAL_W(LZC_WIDTH), .IDX_W(IDX_W)) u_node (
            .i_a_val (w_fv[2*gi]),
            .i_a_idx (w_fi[2*gi]),
            .i_b_val (w_fv[2*gi+1]),
            .i_b_idx (w_fi[2*gi+1]),
            .o_val   (w_fv[gi]),
            .o_idx   (w_fi[gi])
         );
      end
      for (gi = NUM_A; gi < 2*NUM_A; gi++) begin : g_stage_a
         assign w_bv[gi] = r_av[gi];
         assign w_bi[gi] = r_ai[gi];
      end
      for (gi = 1; gi < NUM_A; gi++) begin : g_back_node
         min_idx_2in #(.VAL_W(LZC_WIDTH), .IDX_W(IDX_W)) u_node (
            .i_a_val (w_bv[2*gi]),
            .i_a_idx (w_bi[2*gi]),
            .i_b_val (w_bv[2*gi+1]),
            .i_b_idx (w_bi[2*gi+1]),
            .o_val   (w_bv[gi]),
            .o_idx   (w_bi[gi])
         );
      end
   endgenerate

   // Input capture and Stage A; a reset drops any beat in flight.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_in_vld  <= 1'b0;
         r_in_last <= 1'b0;
         r_a_vld   <= 1'b0;
         r_a_last  <= 1'b0;
         for (int i = 0; i < NUM_IN; i++) r_in_val[i] <= '0;
         for (int k = NUM_A; k < 2*NUM_A; k++) begin
            r_av[k] <= '0;
            r_ai[k] <= '0;
         end
      end else if (en) begin
         r_in_vld  <= stream.in_valid;
         r_in_last <= stream.in_valid & stream.in_last;
         r_a_vld   <= r_in_vld;
         r_a_last  <= r_in_last;
         for (int i = 0; i < NUM_IN; i++) r_in_val[i] <= stream.min_in[i];
         for (int k = NUM_A; k < 2*NUM_A; k++) begin
            r_av[k] <= w_fv[k];
            r_ai[k] <= w_fi[k];
         end
      end
   end

   // Earlier beat keeps the win on a tie, so only a strictly smaller beat min replaces it.
   always_comb begin
      w_take = (w_bv[1] < r_acc_val);
      if (w_take) begin
         w_new_val  = w_bv[1];
         w_new_lane = w_bi[1];
         w_new_beat = r_cnt;
      end else begin
         w_new_val  = r_acc_val;
         w_new_lane = r_acc_lane;
         w_new_beat = r_acc_beat;
      end
   end

   // Frame FSM with accumulator and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= ST_IDLE;
         r_acc_val     <= '0;
         r_acc_lane    <= '0;
         r_acc_beat    <= '0;
         r_cnt         <= '0;
         r_full        <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_min   <= '0;
         r_frame_lane  <= '0;
         r_frame_beat  <= '0;
         r_frame_sat   <= 1'b0;
      end else if (en) begin
         r_frame_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_a_vld && r_a_last) begin
                  r_frame_valid <= 1'b1;
                  r_frame_min   <= w_bv[1];
                  r_frame_lane  <= w_bi[1];
                  r_frame_beat  <= '0;
                  r_frame_sat   <= 1'b0;
               end else if (r_a_vld) begin
                  r_acc_val  <= w_bv[1];
                  r_acc_lane <= w_bi[1];
                  r_acc_beat <= '0;
                  r_cnt      <= BEAT_W'(1);
                  r_full     <= 1'b0;
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (r_a_vld && r_a_last) begin
                  r_frame_valid <= 1'b1;
                  r_frame_min   <= w_new_val;
                  r_frame_lane  <= w_new_lane;
                  r_frame_beat  <= w_new_beat;
                  r_frame_sat   <= r_full;
                  r_state       <= ST_IDLE;
               end else if (r_a_vld) begin
                  r_acc_val  <= w_new_val;
                  r_acc_lane <= w_new_lane;
                  r_acc_beat <= w_new_beat;
                  // r_full marks that beat number BEAT_MAX is used; any later beat overflows.
                  if (r_cnt == BEAT_MAX) begin
                     r_full <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + BEAT_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stream.frame_valid = r_frame_valid;
   assign stream.frame_min   = r_frame_min;
   assign stream.frame_lane  = r_frame_lane;
   assign stream.frame_beat  = r_frame_beat;
   assign stream.frame_sat   = r_frame_sat;

endmodule

// File: tb/tb_min_detect_stream.sv
// Directed bench for min_detect_stream: default instance plus a BEAT_W=2
// instance for beat-counter saturation.
module tb_min_detect_stream;

   logic clk;
   logic rstn;
   logic en;
   int   n_vec;
   int   n_err;

   min_detect_stream_if #(.LZC_WIDTH(5), .NUM_IN(16), .BEAT_W(8)) ifa ();
   min_detect_stream_if #(.LZC_WIDTH(5), .NUM_IN(16), .BEAT_W(2)) ifb ();

   min_detect_stream #(.LZC_WIDTH(5), .NUM_IN(16), .PIPE_LVL(2), .BEAT_W(8)) u_dut_a (
      .clk    (clk),
      .rstn   (rstn),
      .en     (en),
      .stream (ifa)
   );

   min_detect_stream #(.LZC_WIDTH(5), .NUM_IN(16), .PIPE_LVL(2), .BEAT_W(2)) u_dut_b (
      .clk    (clk),
      .rstn   (rstn),
      .en     (en),
      .stream (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int v, input int mn, input int ln,
                        input int bt, input int st);
      chk({tag, "_valid"}, 32'(ifa.frame_valid), 32'(v));
      chk({tag, "_min"},   32'(ifa.frame_min),   32'(mn));
      chk({tag, "_lane"},  32'(ifa.frame_lane),  32'(ln));
      chk({tag, "_beat"},  32'(ifa.frame_beat),  32'(bt));
      chk({tag, "_sat"},   32'(ifa.frame_sat),   32'(st));
   endtask

   task automatic chk_b(input string tag, input int v, input int mn, input int ln,
                        input int bt, input int st);
      chk({tag, "_valid"}, 32'(ifb.frame_valid), 32'(v));
      chk({tag, "_min"},   32'(ifb.frame_min),   32'(mn));
      chk({tag, "_lane"},  32'(ifb.frame_lane),  32'(ln));
      chk({tag, "_beat"},  32'(ifb.frame_beat),  32'(bt));
      chk({tag, "_sat"},   32'(ifb.frame_sat),   32'(st));
   endtask

   // All lanes at base except one lane at val.
   task automatic beat_a(input int base, input int lane, input int val, input bit last);
      ifa.in_valid = 1'b1;
      ifa.in_last  = last;
      for (int i = 0; i < 16; i++) ifa.min_in[i] = (i == lane) ? 5'(val) : 5'(base);
   endtask

   task automatic beat_b(input int base, input int lane, input int val, input bit last);
      ifb.in_valid = 1'b1;
      ifb.in_last  = last;
      for (int i = 0; i < 16; i++) ifb.min_in[i] = (i == lane) ? 5'(val) : 5'(base);
   endtask

   task automatic idle_a();
      ifa.in_valid = 1'b0;
      ifa.in_last  = 1'b0;
   endtask

   task automatic idle_b();
      ifb.in_valid = 1'b0;
      ifb.in_last  = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rstn  = 1'b0;
      en    = 1'b1;
      idle_a();
      idle_b();
      for (int i = 0; i < 16; i++) begin
         ifa.min_in[i] = 5'd0;
         ifb.min_in[i] = 5'd0;
      end

      // Reset state
      tick();
      tick();
      chk_a("rst_a", 0, 0, 0, 0, 0);
      chk_b("rst_b", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      tick();

      // Single beat, lane 9 = 3; result exactly two edges after acceptance
      beat_a(31, 9, 3, 1'b1);
      tick();
      idle_a();
      tick();
      chk("t1_early", 32'(ifa.frame_valid), 32'd0);
      tick();
      chk_a("t1", 1, 3, 9, 0, 0);
      tick();
      chk_a("t1_hold", 0, 3, 9, 0, 0);

      // Lane tie: lanes 4 and 11 both 2
      beat_a(20, 4, 2, 1'b1);
      ifa.min_in[11] = 5'd2;
      tick();
      idle_a();
      tick();
      tick();
      chk_a("t2_tie", 1, 2, 4, 0, 0);

      // Beat tie: mins 5, 2, 2 -> earliest 2 (beat 1, lane 7)
      beat_a(25, 3, 5, 1'b0);
      tick();
      beat_a(25, 7, 2, 1'b0);
      tick();
      beat_a(25, 1, 2, 1'b1);
      tick();
      idle_a();
      tick();
      chk("t3_early", 32'(ifa.frame_valid), 32'd0);
      tick();
      chk_a("t3", 1, 2, 7, 1, 0);

      // Back-to-back single-beat frames
      beat_a(30, 12, 7, 1'b1);
      tick();
      beat_a(30, 2, 1, 1'b1);
      tick();
      idle_a();
      tick();
      chk_a("t4a", 1, 7, 12, 0, 0);
      tick();
      chk_a("t4b", 1, 1, 2, 0, 0);
      tick();
      chk("t4_end", 32'(ifa.frame_valid), 32'd0);

      // en low for 3 cycles inside a 4-beat frame
      beat_a(28, 5, 10, 1'b0);
      tick();
      beat_a(28, 14, 4, 1'b0);
      tick();
      en = 1'b0;
      beat_a(28, 0, 6, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("t5_stall", 32'(ifa.frame_valid), 32'd0);
      end
      en = 1'b1;
      tick();
      beat_a(28, 8, 9, 1'b1);
      tick();
      idle_a();
      tick();
      chk("t5_early", 32'(ifa.frame_valid), 32'd0);
      tick();
      chk_a("t5", 1, 4, 14, 1, 0);
      en = 1'b0;
      tick();
      chk("t5_vld_hold", 32'(ifa.frame_valid), 32'd1);
      en = 1'b1;
      tick();
      chk("t5_vld_drop", 32'(ifa.frame_valid), 32'd0);

      // Reset after beat 2 of 4, then a fresh 1-beat frame
      beat_a(25, 1, 3, 1'b0);
      tick();
      beat_a(25, 2, 4, 1'b0);
      tick();
      idle_a();
      rstn = 1'b0;
      tick();
      chk_a("t6_rst", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      tick();
      tick();
      chk("t6_no_emit", 32'(ifa.frame_valid), 32'd0);
      beat_a(25, 6, 9, 1'b1);
      tick();
      idle_a();
      tick();
      chk("t6_early", 32'(ifa.frame_valid), 32'd0);
      tick();
      chk_a("t6", 1, 9, 6, 0, 0);

      // BEAT_W=2: 4 beats fit without saturation
      for (int i = 0; i < 4; i++) begin
         beat_b(20, 15, 12 - i, (i == 3));
         tick();
      end
      idle_b();
      tick();
      tick();
      chk_b("t7_4beat", 1, 9, 15, 3, 0);

      // BEAT_W=2: 6 beats, min in beat 5 -> beat saturates at 3
      for (int i = 0; i < 6; i++) begin
         beat_b(20, i, (i == 5) ? 1 : 10 - i, (i == 5));
         tick();
      end
      idle_b();
      tick();
      tick();
      chk_b("t7_sat", 1, 1, 5, 3, 1);

      // Saturation flag does not leak into the next frame
      beat_b(20, 0, 4, 1'b1);
      tick();
      idle_b();
      tick();
      tick();
      chk_b("t7_clr", 1, 4, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
